aes_key_expander: RTL and testbench
===================================

// Module: aes_key_expander
// PURPOSE
// - Iterative AES-128 key schedule, upstream of the Decrypt stage: expands a 128-bit cipher key into 11 round keys.
// - Produces one round key per clock and stores all 11 in an internal register file.
// - Decrypt reads round keys by index through a combinational read port.
// PARAMETERS
// - ROUNDS   10   number of cipher rounds; only 10 (AES-128) is legal
// - KEY_W    128  key / round-key width in bits
// PORTS
// - clk        input   1       system clock, all state on rising edge
// - reset      input   1       synchronous, active-high
// - start      input   1       request expansion of key; sampled on clk when busy=0
// - key        input   [0:127] cipher key; bit 0 = MSB of byte 0; w0 = key[0:31]
// - busy       output  1       expansion in progress
// - done       output  1       one-cycle pulse when round key 10 is written
// - key_valid  output  1       all 11 round keys valid; sticky until next accepted start or reset
// - rd_round   input   [3:0]   round-key index for read port
// - rd_key     output  [0:127] round key selected by rd_round (combinational)
// BEHAVIOUR
// - FSM states: IDLE, EXPAND. Counter rnd[3:0].
// - Reset: state=IDLE, rnd=0, busy=0, done=0, key_valid=0. Register-file contents are don't-care.
//   rd_key reads 0 while key_valid=0.
// - IDLE, start=1 at edge T: rk[0]<=key, rnd<=1, busy<=1, key_valid<=0, state<=EXPAND.
// - EXPAND at each edge: rk[rnd] is computed from rk[rnd-1] and Rcon[rnd]:
//   - temp = SubWord(RotWord(w3)) ^ {Rcon[rnd],24'h0}
//   - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
//   - rnd increments after each write.
// - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
// - SubWord is four FIPS-197 S-box lookups, combinational.
// - Latency: rk[10] is written at edge T+10. At that edge: done<=1 for one cycle, busy<=0, key_valid<=1, state<=IDLE.
// - start while busy=1: ignored, with no effect on rnd or key.
// - key input is sampled only at the accepting edge; later changes are ignored.
// - start in the cycle done=1: busy=0, so the request is accepted and key_valid clears at that edge.
// - Reset mid-expansion: the reset behaviour above applies; a partial schedule is never flagged valid.
// - rd_round > ROUNDS: rd_key = 0.
// - Read port is combinational: rd_key = (key_valid && rd_round<=ROUNDS) ? rk[idx] : 0.
// CONFIGURATION
// - Macro: AES_KEYEXP_REVERSE_EN
//   - Defined: idx = ROUNDS - rd_round. rd_round=0 returns rk[10] (decryption order), so Decrypt can count up.
//   - Undefined: idx = rd_round. rd_round=0 returns rk[0] (encryption order).
//   - Range check on rd_round > ROUNDS applies in both builds.
// TESTING
// - FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
//   -> done pulses exactly 10 cycles after the start edge;
//   -> rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
// - Read sweep rd_round 0..15 after done:
//   -> rk[0]=the key in the non-reverse build; rd_round 0 gives rk[10] in the reverse build;
//   -> rd_round 11..15 -> 0.
// - start held high for 20 cycles with key changing each cycle:
//   -> only the first key is expanded; a second expansion starts at the done cycle;
//   -> key_valid low between them.
// - reset at edge T+5 of an expansion:
//   -> busy=0, key_valid=0, done never pulses; rd_key=0 for every index.
// - Back-to-back: key A, then key all-zero started in the done cycle:
//   -> rk[10] for key 00..00 = b4ef5bcb3e92e21123e951cf6f8f188e.
// - Both builds (macro defined / undefined) are simulated with the same vectors.

Source files
------------

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry register file.
// Optional build macro AES_KEYEXP_REVERSE_EN makes the read port return round keys in decryption order.
module aes_key_expander #(
    parameter int ROUNDS = 10,
    parameter int KEY_W  = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [0:KEY_W-1] key,
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    input  logic [3:0]       rd_round,
    output logic [0:KEY_W-1] rd_key
);

    // state  | meaning
    // IDLE   | waiting for start; register file holds the last schedule
    // EXPAND | writing rk[rnd] from rk[rnd-1] once per clock
    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic             done_q, done_d;
    logic             key_valid_q, key_valid_d;
    logic [0:KEY_W-1] rk_q [0:ROUNDS];
    logic [0:KEY_W-1] rk_d [0:ROUNDS];

    logic [0:KEY_W-1] prev_rk, next_rk;
    logic [31:0]      w0, w1, w2, w3, rot_w, sub_w, temp_w;
    logic [31:0]      w0_n, w1_n, w2_n, w3_n;
    logic [3:0]       rd_idx;

    always_comb begin
        prev_rk = rk_q[rnd_q - 4'd1];
        w0      = prev_rk[0:31];
        w1      = prev_rk[32:63];
        w2      = prev_rk[64:95];
        w3      = prev_rk[96:127];
        rot_w   = {w3[23:0], w3[31:24]};
        sub_w   = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
        temp_w  = sub_w ^ {rcon(rnd_q), 24'h0};
        w0_n    = w0 ^ temp_w;
        w1_n    = w1 ^ w0_n;
        w2_n    = w2 ^ w1_n;
        w3_n    = w3 ^ w2_n;
        next_rk = {w0_n, w1_n, w2_n, w3_n};
    end

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        done_d      = 1'b0;
        key_valid_d = key_valid_q;
        rk_d        = rk_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rk_d[0]     = key;
                    rnd_d       = 4'd1;
                    key_valid_d = 1'b0;
                    state_d     = EXPAND;
                end
            end
            EXPAND: begin
                rk_d[rnd_q] = next_rk;
                if (rnd_q == LAST) begin
                    rnd_d       = 4'd0;
                    done_d      = 1'b1;
                    key_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Contents are only trusted when key_valid is set, so no reset is needed here.
    always_ff @(posedge clk) begin
        rk_q <= rk_d;
    end

    always_comb begin
`ifdef AES_KEYEXP_REVERSE_EN
        rd_idx = LAST - rd_round;
`else
        rd_idx = rd_round;
`endif
        rd_key = '0;
        if (key_valid_q && (rd_round <= LAST)) begin
            rd_key = rk_q[rd_idx];
        end
    end

    assign busy      = (state_q == EXPAND);
    assign done      = done_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key schedule vectors.
// Works in both builds; expected read order follows AES_KEYEXP_REVERSE_EN.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [0:127] key;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [3:0]   rd_round;
    logic [0:127] rd_key;

    int vectors     = 0;
    int miscompares = 0;

    logic [0:127] key_a1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [0:127] rk1_zero = 128'h62636363626363636263636362636363;
    logic [0:127] rk10_zero = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    logic [0:127] exp_a1 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_key_expander dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .rd_round  (rd_round),
        .rd_key    (rd_key)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // rd_round value that addresses logical round key i in this build
    function automatic logic [3:0] rd_of(input int i);
`ifdef AES_KEYEXP_REVERSE_EN
        return 4'(10 - i);
`else
        return 4'(i);
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            tick();
            if (done === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; key = '0; rd_round = 4'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL reset_rd_key: got %h expected 0", rd_key); end
    endtask

    task automatic test_fips_a1;
        int got;
        start = 1'b1; key = key_a1;
        tick();
        start = 1'b0; key = 128'hffeeddccbbaa99887766554433221100;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL a1_busy_after_start: got %b expected 1", busy); end
        got = -1;
        for (int n = 1; n <= 20; n++) begin
            start = (n == 3);
            key   = {4{32'h5a5a0000 | 32'(n)}};
            tick();
            if (done === 1'b1) begin
                got = n;
                break;
            end
        end
        start = 1'b0;
        vectors++; if (got != 10) begin miscompares++; $display("FAIL a1_latency: got %0d cycles expected 10", got); end
        vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("FAIL a1_key_valid: got %b expected 1", key_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL a1_busy_at_done: got %b expected 0", busy); end
        rd_round = rd_of(1); #1;
        vectors++; if (rd_key !== exp_a1[1]) begin miscompares++; $display("FAIL a1_rk1: got %h expected %h", rd_key, exp_a1[1]); end
        rd_round = rd_of(10); #1;
        vectors++; if (rd_key !== exp_a1[10]) begin miscompares++; $display("FAIL a1_rk10: got %h expected %h", rd_key, exp_a1[10]); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL a1_done_one_cycle: got %b expected 0", done); end
        vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("FAIL a1_key_valid_sticky: got %b expected 1", key_valid); end
    endtask

    task automatic test_read_sweep;
        logic [0:127] exp;
        for (int r = 0; r <= 15; r++) begin
            rd_round = 4'(r);
            #1;
            if (r > 10) exp = '0;
`ifdef AES_KEYEXP_REVERSE_EN
            else exp = exp_a1[10 - r];
`else
            else exp = exp_a1[r];
`endif
            vectors++;
            if (rd_key !== exp) begin
                miscompares++;
                $display("FAIL sweep_rd_round_%0d: got %h expected %h", r, rd_key, exp);
            end
        end
    endtask

    task automatic test_start_held;
        logic early_done;
        int   n;
        early_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            if (i == 0)       key = key_a1;
            else if (i == 11) key = '0;
            else              key = {4{32'h0bad0000 | 32'(i)}};
            tick();
            if (i >= 1 && i <= 9 && done === 1'b1) early_done = 1'b1;
            if (i == 10) begin
                vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL held_first_done: got %b expected 1", done); end
                vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("FAIL held_first_valid: got %b expected 1", key_valid); end
                rd_round = rd_of(10); #1;
                vectors++; if (rd_key !== exp_a1[10]) begin miscompares++; $display("FAIL held_first_rk10: got %h expected %h", rd_key, exp_a1[10]); end
            end
            if (i == 11) begin
                vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL held_valid_low_between: got %b expected 0", key_valid); end
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL held_second_busy: got %b expected 1", busy); end
            end
        end
        start = 1'b0;
        vectors++; if (early_done !== 1'b0) begin miscompares++; $display("FAIL held_early_done: got %b expected 0", early_done); end
        wait_done(10, n);
        vectors++; if (n != 2) begin miscompares++; $display("FAIL held_second_done_time: got %0d expected 2", n); end
        rd_round = rd_of(0); #1;
        vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL held_second_rk0: got %h expected 0", rd_key); end
        rd_round = rd_of(1); #1;
        vectors++; if (rd_key !== rk1_zero) begin miscompares++; $display("FAIL held_second_rk1: got %h expected %h", rd_key, rk1_zero); end
        rd_round = rd_of(10); #1;
        vectors++; if (rd_key !== rk10_zero) begin miscompares++; $display("FAIL held_second_rk10: got %h expected %h", rd_key, rk10_zero); end
    endtask

    task automatic test_reset_mid;
        logic saw_done;
        start = 1'b1; key = key_a1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_key_valid: got %b expected 0", key_valid); end
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL midrst_done_pulsed: got %b expected 0", saw_done); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_key_valid_late: got %b expected 0", key_valid); end
        for (int r = 0; r <= 15; r++) begin
            rd_round = 4'(r);
            #1;
            vectors++;
            if (rd_key !== 128'h0) begin
                miscompares++;
                $display("FAIL midrst_rd_round_%0d: got %h expected 0", r, rd_key);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        start = 1'b1; key = key_a1;
        tick();
        start = 1'b0;
        wait_done(20, n);
        vectors++; if (n != 10) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 10", n); end
        start = 1'b1; key = '0;
        tick();
        start = 1'b0; key = key_a1;
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_cleared: got %b expected 0", key_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_low: got %b expected 0", done); end
        wait_done(20, n);
        vectors++; if (n != 10) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 10", n); end
        rd_round = rd_of(10); #1;
        vectors++; if (rd_key !== rk10_zero) begin miscompares++; $display("FAIL b2b_zero_rk10: got %h expected %h", rd_key, rk10_zero); end
        rd_round = rd_of(0); #1;
        vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL b2b_zero_rk0: got %h expected 0", rd_key); end
    endtask

    initial begin
        test_reset();
        test_fips_a1();
        test_read_sweep();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
